// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column scan, frame debounce, single-key report FSM.
// Define KEYPAD_REPEAT_EN to enable auto-repeat of a held key.
module keypad_scan #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [15:0] onehot,
  output logic        key_valid,
  output logic        multi_key
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int MW = $clog2(DEBOUNCE_FRAMES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_MAX  = MW'(DEBOUNCE_FRAMES - 1);

  typedef enum logic {ST_RELEASED = 1'b0, ST_PRESSED = 1'b1} state_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

  logic [3:0]    row_s1_r, row_s2_r;
  logic [DW-1:0] dwell_r;
  logic [1:0]    col_r;
  logic [15:0]   build_r, snap_r;
  logic [MW-1:0] match_r;
  state_t        state_r;
  logic          pend_r;

  logic          sample_s, frame_end_s, stable_s;
  logic [15:0]   frame_s;
  logic [MW-1:0] match_nxt_s;
  logic [4:0]    pop_s;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(2 * REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] RPT_FIRST = RW'(2 * REPEAT_FRAMES);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_FRAMES);
  logic [RW-1:0] rpt_cnt_r;
  logic          rpt_first_r;
  logic [RW-1:0] rpt_thr_s;
  assign rpt_thr_s = rpt_first_r ? RPT_FIRST : RPT_NEXT;
`endif

  // Two-flop synchronizer for the asynchronous row inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1_r <= 4'hF;
      row_s2_r <= 4'hF;
    end else begin
      row_s1_r <= row_n;
      row_s2_r <= row_s1_r;
    end
  end

  // Merge the current column's rows into the partially built frame
  always_comb begin
    frame_s = build_r;
    for (int r = 0; r < 4; r++) frame_s[{2'(r), col_r}] = ~row_s2_r[r];
  end

  // Debounce count the frame would reach if this were a frame end
  always_comb begin
    match_nxt_s = {MW{1'b0}};
    if (frame_s == snap_r) begin
      if (match_r == MATCH_MAX) match_nxt_s = match_r;
      else                      match_nxt_s = match_r + 1'b1;
    end else begin
      match_nxt_s = {MW{1'b0}};
    end
  end

  assign sample_s    = (dwell_r == DWELL_LAST);
  assign frame_end_s = sample_s && (col_r == 2'd3);
  assign stable_s    = frame_end_s && (match_nxt_s == MATCH_MAX);
  assign pop_s       = popcount16(frame_s);

  // Column scan, frame assembly and debounce counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_r <= {DW{1'b0}};
      col_r   <= 2'd0;
      col_n   <= 4'b1110;
      build_r <= 16'h0000;
      snap_r  <= 16'h0000;
      match_r <= {MW{1'b0}};
    end else if (sample_s) begin
      dwell_r <= {DW{1'b0}};
      col_r   <= col_r + 2'd1;
      col_n   <= {col_n[2:0], col_n[3]};
      build_r <= frame_s;
      if (frame_end_s) begin
        snap_r  <= frame_s;
        match_r <= match_nxt_s;
      end
    end else begin
      dwell_r <= dwell_r + 1'b1;
    end
  end

  // Report FSM; key_valid trails the onehot update by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_RELEASED;
      onehot      <= 16'h0000;
      pend_r      <= 1'b0;
      key_valid   <= 1'b0;
      multi_key   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_r   <= {RW{1'b0}};
      rpt_first_r <= 1'b1;
`endif
    end else begin
      key_valid <= pend_r;
      pend_r    <= 1'b0;
      if (stable_s) begin
        multi_key <= (pop_s >= 5'd2);
        case (state_r)
          ST_RELEASED: begin
            if (pop_s == 5'd1) begin
              onehot  <= frame_s;
              pend_r  <= 1'b1;
              state_r <= ST_PRESSED;
`ifdef KEYPAD_REPEAT_EN
              rpt_cnt_r   <= {RW{1'b0}};
              rpt_first_r <= 1'b1;
`endif
            end
          end
          ST_PRESSED: begin
            if (frame_s == 16'h0000) begin
              onehot  <= 16'h0000;
              state_r <= ST_RELEASED;
`ifdef KEYPAD_REPEAT_EN
              rpt_cnt_r   <= {RW{1'b0}};
              rpt_first_r <= 1'b1;
            end else if (frame_s == onehot) begin
              if (rpt_cnt_r + 1'b1 == rpt_thr_s) begin
                pend_r      <= 1'b1;
                rpt_cnt_r   <= {RW{1'b0}};
                rpt_first_r <= 1'b0;
              end else begin
                rpt_cnt_r <= rpt_cnt_r + 1'b1;
              end
`endif
            end
          end
          default: begin
            state_r <= ST_RELEASED;
            onehot  <= 16'h0000;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: expected reports queued, checked on each key_valid.
module tb_keypad_scan;
  localparam int FR = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_n, col_n;
  logic [15:0] onehot, keys;
  logic        key_valid, multi_key;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3), .REPEAT_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
    .onehot(onehot), .key_valid(key_valid), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // Passive keypad: a pressed key shorts its row to the driven-low column
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frame();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      prev = col_n;
      @(posedge clk);
      #1;
      if (col_n == 4'b1110 && prev == 4'b0111) found = 1'b1;
    end
    check("frame_align", {31'd0, found}, 32'd1);
  endtask

  // Monitor: every key_valid pulse must match the oldest queued report
  always @(negedge clk) begin
    if (!rst && key_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_pulse", {16'd0, onehot}, 32'hFFFF_FFFF);
      else check("pulse_onehot", {16'd0, onehot}, {16'd0, exp_q.pop_front()});
    end
  end

  initial begin
    keys = 16'h0000;
    rst  = 1'b1;
    tick(3);
    check("rst_col_n", {28'd0, col_n}, 32'hE);
    check("rst_onehot", {16'd0, onehot}, 32'd0);
    check("rst_kv_mk", {30'd0, key_valid, multi_key}, 32'd0);

    // Idle scan sequence after reset release
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 40; k++) begin
      logic [3:0] ec;
      ec = ~(4'b0001 << ((k / 4) % 4));
      check("idle_col_n", {28'd0, col_n}, {28'd0, ec});
      check("idle_outs", {15'd0, onehot, key_valid, multi_key}, 32'd0);
      tick(1);
    end

    // Single key (2,1) press and release
    wait_frame();
    keys = 16'h0200;
    exp_q.push_back(16'h0200);
    tick(2 * FR);
    check("k21_not_yet", {16'd0, onehot}, 32'd0);
    tick(2 * FR);
    check("k21_report", {16'd0, onehot}, 32'h0200);
    keys = 16'h0000;
    tick(2 * FR);
    check("k21_held_deb", {16'd0, onehot}, 32'h0200);
    tick(FR);
    check("k21_release", {16'd0, onehot}, 32'd0);
    tick(2 * FR);

    // Chatter on (0,0) for five frames, then held
    wait_frame();
    exp_q.push_back(16'h0001);
    for (int i = 0; i < 8; i++) begin
      keys = (i % 2 == 0) ? 16'h0001 : 16'h0000;
      tick(10);
    end
    keys = 16'h0001;
    check("chatter_quiet", {16'd0, onehot}, 32'd0);
    tick(3 * FR);
    check("chatter_report", {16'd0, onehot}, 32'h0001);
    keys = 16'h0000;
    tick(5 * FR);
    check("chatter_release", {16'd0, onehot}, 32'd0);

    // Two keys together, then roll-over attempt
    wait_frame();
    keys = 16'h8001;
    tick(5 * FR);
    check("multi_flag", {31'd0, multi_key}, 32'd1);
    check("multi_onehot", {16'd0, onehot}, 32'd0);
    keys = 16'h0000;
    tick(5 * FR);
    check("multi_clear", {31'd0, multi_key}, 32'd0);
    keys = 16'h0001;
    exp_q.push_back(16'h0001);
    tick(4 * FR);
    check("roll_first", {16'd0, onehot}, 32'h0001);
    keys = 16'h0021;
    tick(4 * FR);
    check("roll_blocked", {16'd0, onehot}, 32'h0001);
    check("roll_multi", {31'd0, multi_key}, 32'd1);
    keys = 16'h0000;
    tick(5 * FR);
    check("roll_release", {16'd0, onehot, multi_key}, 32'd0);

    // Long hold of (1,1): repeat pulses only with the repeat build
    wait_frame();
    keys = 16'h0020;
    exp_q.push_back(16'h0020);
`ifdef KEYPAD_REPEAT_EN
    exp_q.push_back(16'h0020);
    exp_q.push_back(16'h0020);
    exp_q.push_back(16'h0020);
`endif
    tick(12 * FR);
    check("hold_onehot", {16'd0, onehot}, 32'h0020);
    keys = 16'h0000;
    tick(5 * FR);
    check("hold_release", {16'd0, onehot}, 32'd0);
    check("hold_pulses", exp_q.size(), 32'd0);

    // Reset in the middle of a press
    wait_frame();
    keys = 16'h0020;
    exp_q.push_back(16'h0020);
    tick(4 * FR);
    check("pre_rst_onehot", {16'd0, onehot}, 32'h0020);
    tick(5);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_col_n", {28'd0, col_n}, 32'hE);
    check("async_rst_outs", {15'd0, onehot, key_valid, multi_key}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(16'h0020);
    tick(2 * FR);
    check("post_rst_quiet", {16'd0, onehot}, 32'd0);
    tick(2 * FR);
    check("post_rst_report", {16'd0, onehot}, 32'h0020);
    keys = 16'h0000;
    tick(5 * FR);
    check("final_release", {16'd0, onehot}, 32'd0);
    check("all_pulses_seen", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
